i2c_reg_target: RTL and testbench

//  Synthesizable I2C target (slave) exposing a register file. Replaces behavioural sensor models with RTL usable in sim and on FPGA.

---
 rtl/i2c_reg_target.sv | 248 ++++++++++++++++++++++++
 tb/tb_i2c_reg_target.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_target.sv
// ============================================================================
// i2c_reg_target : I2C target exposing a byte register file, with host port
// Revision: 1.0
// ============================================================================
`default_nettype none

module i2c_reg_target #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h68,
    parameter int         REG_AW      = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              dev_clk,
    input  logic              rst_n,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    input  logic              host_we,
    input  logic [REG_AW-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              wr_strobe,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);

    localparam int                DEPTH   = 1 << REG_AW;
    localparam logic [REG_AW-1:0] PTR_ONE = REG_AW'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_REG  = 3'd2,
        S_WR   = 3'd3,
        S_RD   = 3'd4,
        S_WAIT = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_ev;
    logic stop_ev;

    state_t            state_q,     state_d;
    logic [3:0]        bitcnt_q,    bitcnt_d;
    logic [7:0]        shift_q,     shift_d;
    logic [REG_AW-1:0] ptr_q,       ptr_d;
    logic              sda_oe_q,    sda_oe_d;
    logic              busy_q,      busy_d;
    logic              wr_strobe_q;
    logic [REG_AW-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic [7:0]        host_rdata_q;

    logic [7:0] mem_q [0:DEPTH-1];

    logic       commit;
    logic [7:0] rx_byte;
    logic [7:0] rd_byte;

    // Bus idles high, so the synchronisers reset to 1 to avoid a false START.
    always_ff @(posedge dev_clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    assign start_ev = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_ev  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    assign rx_byte = {shift_q[6:0], sda_s};
    assign rd_byte = mem_q[ptr_q];

    // bitcnt counts SCL rises within a 9-clock frame: 1..8 data, 9 = ACK.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        sda_oe_d = sda_oe_q;
        busy_d   = busy_q;
        commit   = 1'b0;

        if (start_ev) begin
            state_d  = S_ADDR;
            bitcnt_d = 4'd0;
            sda_oe_d = 1'b0;
        end else if (stop_ev) begin
            state_d  = S_IDLE;
            bitcnt_d = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end

                S_ADDR, S_REG, S_WR: begin
                    if (scl_rise) begin
                        if (bitcnt_q < 4'd8) begin
                            shift_d  = rx_byte;
                            bitcnt_d = bitcnt_q + 4'd1;
                            if (bitcnt_q == 4'd7) begin
                                if (state_q == S_ADDR && rx_byte[7:1] != SLAVE_ADDR) begin
                                    state_d  = S_IDLE;
                                    bitcnt_d = 4'd0;
                                end
                                if (state_q == S_REG) begin
                                    ptr_d = rx_byte[REG_AW-1:0];
                                end
                                if (state_q == S_WR) begin
                                    commit = 1'b1;
                                    ptr_d  = ptr_q + PTR_ONE;
                                end
                            end
                        end else if (bitcnt_q == 4'd8) begin
                            bitcnt_d = 4'd9;
                        end
                    end else if (scl_fall) begin
                        if (bitcnt_q == 4'd8) begin
                            sda_oe_d = 1'b1;
                            if (state_q == S_ADDR) begin
                                busy_d = 1'b1;
                            end
                        end else if (bitcnt_q == 4'd9) begin
                            sda_oe_d = 1'b0;
                            bitcnt_d = 4'd0;
                            if (state_q == S_ADDR) begin
                                if (shift_q[0]) begin
                                    state_d  = S_RD;
                                    sda_oe_d = ~rd_byte[7];
                                    shift_d  = {rd_byte[6:0], 1'b0};
                                end else begin
                                    state_d = S_REG;
                                end
                            end else begin
                                state_d = S_WR;
                            end
                        end
                    end
                end

                S_RD: begin
                    if (scl_rise) begin
                        if (bitcnt_q < 4'd8) begin
                            bitcnt_d = bitcnt_q + 4'd1;
                        end else if (bitcnt_q == 4'd8) begin
                            if (sda_s) begin
                                state_d  = S_WAIT;
                                bitcnt_d = 4'd0;
                            end else begin
                                bitcnt_d = 4'd9;
                            end
                        end
                    end else if (scl_fall) begin
                        if (bitcnt_q >= 4'd1 && bitcnt_q <= 4'd7) begin
                            sda_oe_d = ~shift_q[7];
                            shift_d  = {shift_q[6:0], 1'b0};
                        end else if (bitcnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            ptr_d    = ptr_q + PTR_ONE;
                        end else if (bitcnt_q == 4'd9) begin
                            sda_oe_d = ~rd_byte[7];
                            shift_d  = {rd_byte[6:0], 1'b0};
                            bitcnt_d = 4'd0;
                        end
                    end
                end

                S_WAIT: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    state_d  = S_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge dev_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bitcnt_q     <= 4'd0;
            shift_q      <= 8'd0;
            ptr_q        <= '0;
            sda_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 8'd0;
            host_rdata_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            ptr_q        <= ptr_d;
            sda_oe_q     <= sda_oe_d;
            busy_q       <= busy_d;
            wr_strobe_q  <= commit;
            wr_addr_q    <= commit ? ptr_q : wr_addr_q;
            wr_data_q    <= commit ? rx_byte : wr_data_q;
            host_rdata_q <= mem_q[host_addr];
        end
    end

    // Register file keeps its contents through reset; I2C wins an address clash.
    always_ff @(posedge dev_clk) begin
        if (host_we && !(commit && host_addr == ptr_q)) begin
            mem_q[host_addr] <= host_wdata;
        end
        if (commit) begin
            mem_q[ptr_q] <= rx_byte;
        end
    end

    assign sda_oe     = sda_oe_q;
    assign busy       = busy_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign host_rdata = host_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_reg_target.sv
// ============================================================================
// tb_i2c_reg_target : bit-banged I2C master bench with a byte-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_i2c_reg_target;

    localparam int Q = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic scl;
    logic sda_m;
    logic sda_bus;

    logic       oe0, hwe0, ws0, busy0;
    logic [7:0] haddr0, hwd0, hrd0, wa0, wd0;
    logic       oe1, hwe1, ws1, busy1;
    logic [3:0] haddr1, wa1;
    logic [7:0] hwd1, hrd1, wd1;

    assign sda_bus = sda_m & ~oe0 & ~oe1;

    i2c_reg_target #(.SLAVE_ADDR(7'h68), .REG_AW(8), .SYNC_STAGES(2)) u_dut0 (
        .dev_clk(clk), .rst_n(rst_n), .scl_i(scl), .sda_i(sda_bus), .sda_oe(oe0),
        .host_we(hwe0), .host_addr(haddr0), .host_wdata(hwd0), .host_rdata(hrd0),
        .wr_strobe(ws0), .wr_addr(wa0), .wr_data(wd0), .busy(busy0)
    );

    i2c_reg_target #(.SLAVE_ADDR(7'h50), .REG_AW(4), .SYNC_STAGES(2)) u_dut1 (
        .dev_clk(clk), .rst_n(rst_n), .scl_i(scl), .sda_i(sda_bus), .sda_oe(oe1),
        .host_we(hwe1), .host_addr(haddr1), .host_wdata(hwd1), .host_rdata(hrd1),
        .wr_strobe(ws1), .wr_addr(wa1), .wr_data(wd1), .busy(busy1)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  mdl [256];
    logic [7:0]  mptr;
    logic [15:0] strq [$];
    int          str1_cnt;
    logic        oe_seen;

    always @(negedge clk) begin
        if (ws0) strq.push_back({wa0, wd0});
        if (ws1) str1_cnt = str1_cnt + 1;
        if (oe0) oe_seen = 1'b1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic m_start();
        sda_m = 1'b1; q(); scl = 1'b1; q(); sda_m = 1'b0; q(); scl = 1'b0; q();
    endtask

    task automatic m_stop();
        sda_m = 1'b0; q(); scl = 1'b1; q(); sda_m = 1'b1; q();
    endtask

    task automatic m_bit_w(input logic b);
        sda_m = b; q(); scl = 1'b1; q(); q(); scl = 1'b0; q();
    endtask

    task automatic m_bit_r(output logic b);
        sda_m = 1'b1; q(); scl = 1'b1; q(); b = sda_bus; q(); scl = 1'b0; q();
    endtask

    task automatic m_write(input logic [7:0] d, output logic ack);
        logic nak;
        for (int i = 7; i >= 0; i--) m_bit_w(d[i]);
        m_bit_r(nak);
        ack = ~nak;
    endtask

    task automatic m_read(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            m_bit_r(b);
            d[i] = b;
        end
        m_bit_w(~ack);
    endtask

    // Raises host_we exactly in the cycle the 8th SCL rise commits the byte.
    task automatic m_write_coll(input logic [7:0] d, input logic [7:0] ha,
                                input logic [7:0] hd, output logic ack);
        logic nak;
        for (int i = 7; i >= 1; i--) m_bit_w(d[i]);
        sda_m = d[0]; q(); scl = 1'b1;
        @(negedge clk); @(negedge clk);
        hwe0 = 1'b1; haddr0 = ha; hwd0 = hd;
        @(negedge clk);
        hwe0 = 1'b0;
        repeat (Q - 3) @(negedge clk);
        q(); scl = 1'b0; q();
        m_bit_r(nak);
        ack = ~nak;
    endtask

    task automatic host_wr0(input logic [7:0] a, input logic [7:0] d);
        hwe0 = 1'b1; haddr0 = a; hwd0 = d;
        @(negedge clk);
        hwe0 = 1'b0;
        mdl[a] = d;
    endtask

    task automatic host_rd0(input logic [7:0] a, output logic [7:0] d);
        haddr0 = a;
        @(negedge clk);
        d = hrd0;
    endtask

    typedef struct {
        logic [7:0] dev;
        logic [7:0] reg_a;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       exp_ack;
        int         exp_nstr;
    } vec_t;

    vec_t       vt [4];
    logic [7:0] t2 [6];

    initial begin
        logic       a;
        logic [7:0] d;
        logic [7:0] p;
        int         n;
        int         kind;

        vt[0] = '{8'hD0, 8'h6B, 8'h00, 8'h11, 1'b1, 2};
        vt[1] = '{8'hD2, 8'h20, 8'h5A, 8'h5B, 1'b0, 0};
        vt[2] = '{8'hD0, 8'hFF, 8'h77, 8'h88, 1'b1, 2};
        vt[3] = '{8'h10, 8'h44, 8'h99, 8'h98, 1'b0, 0};
        t2[0] = 8'hDE; t2[1] = 8'hAD; t2[2] = 8'hBE;
        t2[3] = 8'hEF; t2[4] = 8'hC0; t2[5] = 8'hDE;

        rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
        hwe0 = 1'b0; haddr0 = 8'd0; hwd0 = 8'd0;
        hwe1 = 1'b0; haddr1 = 4'd0; hwd1 = 8'd0;
        str1_cnt = 0; oe_seen = 1'b0; mptr = 8'd0;
        repeat (4) @(negedge clk);
        chk("reset_sda_oe", oe0, 0);
        chk("reset_wr_strobe", ws0, 0);
        chk("reset_busy", busy0, 0);
        chk("reset_host_rdata", hrd0, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 256; i++) host_wr0(i[7:0], 8'($urandom));

        // Table-driven write frames.
        for (int v = 0; v < 4; v++) begin
            strq.delete();
            oe_seen = 1'b0;
            m_start();
            m_write(vt[v].dev, a);
            chk("vec_addr_ack", a, vt[v].exp_ack);
            m_write(vt[v].reg_a, a);
            m_write(vt[v].d0, a);
            m_write(vt[v].d1, a);
            m_stop();
            q();
            chk("vec_oe_seen", oe_seen, vt[v].exp_ack);
            chk("vec_nstrobe", strq.size(), vt[v].exp_nstr);
            if (vt[v].exp_ack) begin
                mdl[vt[v].reg_a] = vt[v].d0;
                mdl[8'(vt[v].reg_a + 8'd1)] = vt[v].d1;
                mptr = vt[v].reg_a + 8'd2;
                if (strq.size() == 2) begin
                    chk("vec_strobe0", strq[0], {vt[v].reg_a, vt[v].d0});
                    chk("vec_strobe1", strq[1], {8'(vt[v].reg_a + 8'd1), vt[v].d1});
                end
            end
            host_rd0(vt[v].reg_a, d);
            chk("vec_rb0", d, mdl[vt[v].reg_a]);
            host_rd0(8'(vt[v].reg_a + 8'd1), d);
            chk("vec_rb1", d, mdl[8'(vt[v].reg_a + 8'd1)]);
        end

        // Preload, set pointer, repeated START, 6-byte read with NACK.
        for (int i = 0; i < 6; i++) host_wr0(8'(8'h3B + i), t2[i]);
        chk("t2_busy_before", busy0, 0);
        m_start();
        m_write(8'hD0, a);
        m_write(8'h3B, a);
        m_start();
        m_write(8'hD1, a);
        chk("t2_rd_addr_ack", a, 1);
        chk("t2_busy_in_read", busy0, 1);
        for (int k = 0; k < 6; k++) begin
            m_read(d, k < 5);
            chk("t2_read_byte", d, t2[k]);
        end
        mptr = 8'h41;
        q();
        chk("t2_wait_sda_released", oe0, 0);
        chk("t2_busy_in_wait", busy0, 1);
        m_stop();
        q();
        chk("t2_busy_after_stop", busy0, 0);

        // Narrow instance: pointer wraps 0xF -> 0x0.
        m_start();
        m_write(8'hA0, a);
        chk("t4_addr_ack", a, 1);
        m_write(8'h0F, a);
        m_write(8'hA1, a);
        m_write(8'hA2, a);
        m_write(8'hA3, a);
        m_stop();
        q();
        chk("t4_strobes", str1_cnt, 3);
        haddr1 = 4'hF; @(negedge clk); chk("t4_reg_f", hrd1, 8'hA1);
        haddr1 = 4'h0; @(negedge clk); chk("t4_reg_0", hrd1, 8'hA2);
        haddr1 = 4'h1; @(negedge clk); chk("t4_reg_1", hrd1, 8'hA3);

        // STOP after 4 data bits discards the byte.
        strq.delete();
        m_start();
        m_write(8'hD0, a);
        m_write(8'h30, a);
        mptr = 8'h30;
        m_bit_w(1'b1); m_bit_w(1'b0); m_bit_w(1'b1); m_bit_w(1'b1);
        m_stop();
        q();
        chk("t5_no_strobe", strq.size(), 0);
        chk("t5_busy", busy0, 0);
        host_rd0(8'h30, d);
        chk("t5_reg_kept", d, mdl[8'h30]);
        oe_seen = 1'b0;
        m_write(8'hD0, a);
        chk("t5_idle_ignores_addr", a, 0);
        chk("t5_idle_no_oe", oe_seen, 0);

        // Async reset while the target pulls SDA low for a read bit.
        host_wr0(8'h50, 8'h00);
        m_start();
        m_write(8'hD0, a);
        m_write(8'h50, a);
        m_start();
        m_write(8'hD1, a);
        chk("t5_oe_before_reset", oe0, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_oe_async_reset", oe0, 0);
        chk("t5_busy_async_reset", busy0, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        mptr = 8'd0;
        m_stop();
        q();
        host_rd0(8'h3B, d);
        chk("t5_regfile_survives_reset", d, 8'hDE);
        m_start();
        m_write(8'hD1, a);
        m_read(d, 1'b0);
        chk("t5_ptr_zero_after_reset", d, mdl[8'h00]);
        mptr = 8'd1;
        m_stop();

        // Same-cycle host write and I2C commit.
        strq.delete();
        m_start();
        m_write(8'hD0, a);
        m_write(8'h10, a);
        m_write_coll(8'hAA, 8'h10, 8'h55, a);
        mdl[8'h10] = 8'hAA;
        m_write_coll(8'hBB, 8'h20, 8'h66, a);
        mdl[8'h11] = 8'hBB;
        mdl[8'h20] = 8'h66;
        mptr = 8'h12;
        m_stop();
        q();
        chk("t6_nstrobe", strq.size(), 2);
        host_rd0(8'h10, d); chk("t6_i2c_wins", d, 8'hAA);
        host_rd0(8'h11, d); chk("t6_i2c_other", d, 8'hBB);
        host_rd0(8'h20, d); chk("t6_host_other", d, 8'h66);

        // Randomised transactions against the byte-level model.
        for (int it = 0; it < 24; it++) begin
            kind = $urandom_range(0, 2);
            n    = $urandom_range(1, 4);
            p    = 8'($urandom);
            if ($urandom_range(0, 1) == 1) host_wr0(8'($urandom), 8'($urandom));
            if (kind == 0) begin
                strq.delete();
                m_start();
                m_write(8'hD0, a); chk("rnd_addr_ack", a, 1);
                m_write(p, a);     chk("rnd_reg_ack", a, 1);
                mptr = p;
                for (int k = 0; k < n; k++) begin
                    d = 8'($urandom);
                    m_write(d, a);
                    chk("rnd_data_ack", a, 1);
                    mdl[mptr] = d;
                    mptr = mptr + 8'd1;
                end
                m_stop();
                q();
                chk("rnd_nstrobe", strq.size(), n);
                for (int k = 0; k < n && k < strq.size(); k++)
                    chk("rnd_strobe", strq[k], {8'(p + k[7:0]), mdl[8'(p + k[7:0])]});
            end else begin
                m_start();
                if (kind == 1) begin
                    m_write(8'hD0, a);
                    m_write(p, a);
                    mptr = p;
                    m_start();
                end
                m_write(8'hD1, a);
                chk("rnd_rd_addr_ack", a, 1);
                for (int k = 0; k < n; k++) begin
                    m_read(d, k < n - 1);
                    chk("rnd_read", d, mdl[mptr]);
                    mptr = mptr + 8'd1;
                end
                m_stop();
                q();
                chk("rnd_busy_idle", busy0, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
